irq_pending_latch: RTL and testbench

- Upstream request-collection stage for the 8-to-3 encoder.
- Captures pulse or level requests on 8 lines into sticky pending bits.
- Presents a registered, masked, single-hot grant vector for the encoder's data_in.
- The downstream consumer clears serviced bits with an indexed ack; per-line overflow flags record requests lost while already pending.

---
 rtl/irq_pkg.sv | 34 +++
 rtl/req_edge_detect.sv | 29 ++
 rtl/irq_pending_latch.sv | 69 ++++++
 tb/tb_irq_pending_latch.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared widths and one-hot helpers for the interrupt pending latch
package irq_pkg;

    localparam int IRQ_WIDTH = 8;
    localparam int IRQ_IDX_W = 3;

    // Highest set bit of v as a one-hot vector; zero when v is zero.
    function automatic logic [IRQ_WIDTH-1:0] msb_onehot(input logic [IRQ_WIDTH-1:0] v);
        logic [IRQ_WIDTH-1:0] r;
        r = '0;
        // Ascending scan so the last hit (highest index) overwrites lower ones.
        for (int i = 0; i < IRQ_WIDTH; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Decode an index to a one-hot line select; zero when disabled or out of range.
    function automatic logic [IRQ_WIDTH-1:0] idx_to_onehot(input logic [IRQ_IDX_W-1:0] idx,
                                                            input logic                 en);
        logic [IRQ_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < IRQ_WIDTH; i++) begin
            if (en && (idx == IRQ_IDX_W'(i))) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/req_edge_detect.sv
// rtl/req_edge_detect.sv - per-line request event detection (rising edge or level)
module req_edge_detect
    import irq_pkg::*;
#(
    parameter int WIDTH     = IRQ_WIDTH,
    parameter int EDGE_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    output logic [WIDTH-1:0] req_event_o
);

    logic [WIDTH-1:0] req_d_q;

    // Previous-cycle copy of the request lines; cleared by reset so a line
    // held high through reset is seen as a fresh rising edge afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_d_q <= '0;
        end else begin
            req_d_q <= req_in;
        end
    end

    // Select edge or level capture; both operands are always referenced.
    assign req_event_o = (EDGE_MODE != 0) ? (req_in & ~req_d_q) : req_in;

endmodule

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - sticky pending bits with masked one-hot grant for the 8-to-3 encoder
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int WIDTH     = IRQ_WIDTH,
    parameter int IDX_W     = IRQ_IDX_W,
    parameter int EDGE_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    input  logic [WIDTH-1:0] mask,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] grant_onehot,
    output logic             grant_valid,
    output logic [WIDTH-1:0] overflow
);

    logic [WIDTH-1:0] req_event;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] pending_d, pending_q;
    logic [WIDTH-1:0] overflow_d, overflow_q;
    logic [WIDTH-1:0] grant_d, grant_q;
    logic             grant_valid_d, grant_valid_q;

    req_edge_detect #(
        .WIDTH     (WIDTH),
        .EDGE_MODE (EDGE_MODE)
    ) u_req_edge_detect (
        .clk         (clk),
        .rst         (rst),
        .req_in      (req_in),
        .req_event_o (req_event)
    );

    // Next-state: ack clears, new events set (set wins on collision); overflow
    // records an event landing on a line already pending and not being cleared.
    // Grant is computed from next-state pending so it lines up with pending.
    always_comb begin
        clr           = idx_to_onehot(ack_idx, ack);
        pending_d     = (pending_q & ~clr) | req_event;
        overflow_d    = (overflow_q & ~clr) | (req_event & pending_q & ~clr);
        grant_d       = msb_onehot(pending_d & mask);
        grant_valid_d = |(pending_d & mask);
    end

    // All outputs registered; reset discards every piece of pending state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= '0;
            overflow_q    <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign pending      = pending_q;
    assign overflow     = overflow_q;
    assign grant_onehot = grant_q;
    assign grant_valid  = grant_valid_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - vector-table bench for edge and level variants of irq_pending_latch
module tb_irq_pending_latch;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic [2:0] idx;
        logic [7:0] pend;
        logic [7:0] grant;
        logic       gv;
        logic [7:0] ovf;
    } vec_t;

    typedef struct {
        int         which;
        int         row;
        logic [7:0] pend;
        logic [7:0] grant;
        logic       gv;
        logic [7:0] ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] req_e, req_l, mask;
    logic       ack;
    logic [2:0] ack_idx;
    logic [7:0] pend_e, grant_e, ovf_e, pend_l, grant_l, ovf_l;
    logic       gv_e, gv_l;

    int total;
    int bad;
    exp_t sb[$];
    vec_t tbl_e[26];
    vec_t tbl_l[9];

    irq_pending_latch #(.WIDTH(8), .IDX_W(3), .EDGE_MODE(1)) dut_edge (
        .clk(clk), .rst(rst), .req_in(req_e), .mask(mask), .ack(ack), .ack_idx(ack_idx),
        .pending(pend_e), .grant_onehot(grant_e), .grant_valid(gv_e), .overflow(ovf_e)
    );

    irq_pending_latch #(.WIDTH(8), .IDX_W(3), .EDGE_MODE(0)) dut_level (
        .clk(clk), .rst(rst), .req_in(req_l), .mask(mask), .ack(ack), .ack_idx(ack_idx),
        .pending(pend_l), .grant_onehot(grant_l), .grant_valid(gv_l), .overflow(ovf_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp8(input string name, input int row, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s row=%0d actual=%02h required=%02h", name, row, act, req);
        end
    endtask

    task automatic check_one();
        exp_t e;
        e = sb.pop_front();
        if (e.which == 0) begin
            cmp8("edge.pending",  e.row, pend_e,  e.pend);
            cmp8("edge.grant",    e.row, grant_e, e.grant);
            cmp8("edge.gvalid",   e.row, {7'd0, gv_e}, {7'd0, e.gv});
            cmp8("edge.overflow", e.row, ovf_e,   e.ovf);
        end else begin
            cmp8("level.pending",  e.row, pend_l,  e.pend);
            cmp8("level.grant",    e.row, grant_l, e.grant);
            cmp8("level.gvalid",   e.row, {7'd0, gv_l}, {7'd0, e.gv});
            cmp8("level.overflow", e.row, ovf_l,   e.ovf);
        end
    endtask

    task automatic apply(input int which, input int row, input vec_t v);
        exp_t e;
        @(negedge clk);
        rst     = v.rst;
        mask    = v.mask;
        ack     = v.ack;
        ack_idx = v.idx;
        if (which == 0) begin
            req_e = v.req;
            req_l = 8'h00;
        end else begin
            req_l = v.req;
            req_e = 8'h00;
        end
        e.which = which;
        e.row   = row;
        e.pend  = v.pend;
        e.grant = v.grant;
        e.gv    = v.gv;
        e.ovf   = v.ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        req_e   = 8'h00;
        req_l   = 8'h00;
        mask    = 8'hFF;
        ack     = 1'b0;
        ack_idx = 3'd0;

        //            rst   req    mask   ack  idx   pend   grant  gv    ovf
        tbl_e[0]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl_e[1]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl_e[2]  = '{1'b0, 8'hFF, 8'hFF, 1'b0, 3'd0, 8'hFF, 8'h80, 1'b1, 8'h00};
        tbl_e[3]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 3'd7, 8'h7F, 8'h40, 1'b1, 8'h00};
        tbl_e[4]  = '{1'b1, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl_e[5]  = '{1'b0, 8'h24, 8'hFF, 1'b0, 3'd0, 8'h24, 8'h20, 1'b1, 8'h00};
        tbl_e[6]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 3'd5, 8'h04, 8'h04, 1'b1, 8'h00};
        tbl_e[7]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 3'd2, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl_e[8]  = '{1'b0, 8'h81, 8'h7F, 1'b0, 3'd0, 8'h81, 8'h01, 1'b1, 8'h00};
        tbl_e[9]  = '{1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h81, 8'h80, 1'b1, 8'h00};
        tbl_e[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h81, 8'h00, 1'b0, 8'h00};
        tbl_e[11] = '{1'b0, 8'h00, 8'hFF, 1'b1, 3'd0, 8'h80, 8'h80, 1'b1, 8'h00};
        tbl_e[12] = '{1'b0, 8'h00, 8'hFF, 1'b1, 3'd7, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl_e[13] = '{1'b0, 8'h08, 8'hFF, 1'b0, 3'd0, 8'h08, 8'h08, 1'b1, 8'h00};
        tbl_e[14] = '{1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h08, 8'h08, 1'b1, 8'h00};
        tbl_e[15] = '{1'b0, 8'h08, 8'hFF, 1'b1, 3'd3, 8'h08, 8'h08, 1'b1, 8'h00};
        tbl_e[16] = '{1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h08, 8'h08, 1'b1, 8'h00};
        tbl_e[17] = '{1'b0, 8'h08, 8'hFF, 1'b0, 3'd0, 8'h08, 8'h08, 1'b1, 8'h08};
        tbl_e[18] = '{1'b0, 8'h00, 8'hFF, 1'b1, 3'd3, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl_e[19] = '{1'b0, 8'h01, 8'hFF, 1'b0, 3'd0, 8'h01, 8'h01, 1'b1, 8'h00};
        tbl_e[20] = '{1'b0, 8'h00, 8'hFF, 1'b1, 3'd6, 8'h01, 8'h01, 1'b1, 8'h00};
        tbl_e[21] = '{1'b0, 8'h01, 8'hFF, 1'b0, 3'd0, 8'h01, 8'h01, 1'b1, 8'h01};
        tbl_e[22] = '{1'b0, 8'hA5, 8'hFF, 1'b0, 3'd0, 8'hA5, 8'h80, 1'b1, 8'h01};
        tbl_e[23] = '{1'b1, 8'hA5, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl_e[24] = '{1'b0, 8'hA5, 8'hFF, 1'b0, 3'd0, 8'hA5, 8'h80, 1'b1, 8'h00};
        tbl_e[25] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'hA5, 8'h00, 1'b0, 8'h00};

        tbl_l[0]  = '{1'b1, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl_l[1]  = '{1'b0, 8'h02, 8'hFF, 1'b0, 3'd0, 8'h02, 8'h02, 1'b1, 8'h00};
        tbl_l[2]  = '{1'b0, 8'h02, 8'hFF, 1'b0, 3'd0, 8'h02, 8'h02, 1'b1, 8'h02};
        tbl_l[3]  = '{1'b0, 8'h02, 8'hFF, 1'b0, 3'd0, 8'h02, 8'h02, 1'b1, 8'h02};
        tbl_l[4]  = '{1'b0, 8'h02, 8'hFF, 1'b1, 3'd1, 8'h02, 8'h02, 1'b1, 8'h00};
        tbl_l[5]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 3'd1, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl_l[6]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl_l[7]  = '{1'b0, 8'hFF, 8'h0F, 1'b0, 3'd0, 8'hFF, 8'h08, 1'b1, 8'h00};
        tbl_l[8]  = '{1'b0, 8'hFF, 8'h0F, 1'b0, 3'd0, 8'hFF, 8'h08, 1'b1, 8'hFF};

        for (int i = 0; i < 26; i++) begin
            apply(0, i, tbl_e[i]);
        end
        for (int i = 0; i < 9; i++) begin
            apply(1, 100 + i, tbl_l[i]);
        end

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
